stage_mem: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the EX result (reg_waddr/we/reg_wdata) plus load/store controls.
- Runs a req/ack handshake with the data-memory controller and formats load data (byte lanes, sign/zero extension).
- Registers the result into the writeback interface; stalls upstream while an access is outstanding.

---
 rtl/stage_mem_pkg.sv | 32 +++
 rtl/stage_mem_if.sv | 21 ++
 rtl/mem_lane_fmt.sv | 31 +++
 rtl/stage_mem.sv | 146 ++++++++++++++
 tb/tb_stage_mem.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared widths, memory-op codes and FSM encodings for the memory stage
package stage_mem_pkg;
    localparam int REG_W    = 32;
    localparam int REG_AW   = 5;
    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Codes 9..15 fall through both helpers, so they behave as MEM_NONE
    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return op inside {SB, SH, SW};
    endfunction
endpackage

// File: rtl/stage_mem_if.sv
// stage_mem_if: data-memory req/ack bus between the memory stage and the memory controller
interface stage_mem_if;
    import stage_mem_pkg::*;
    logic             mem_req;
    logic             mem_we;
    logic [REG_W-1:0] mem_addr;
    logic [REG_W-1:0] mem_wdata;
    logic [3:0]       mem_wmask;
    logic             mem_ack;
    logic [REG_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: little-endian byte-lane formatting, store mask/replication and load extraction/extension
module mem_lane_fmt
    import stage_mem_pkg::*;
(
    input  logic [MEM_OP_W-1:0] i_st_op,
    input  logic [1:0]          i_st_a,
    input  logic [REG_W-1:0]    i_st_data,
    input  logic [MEM_OP_W-1:0] i_ld_op,
    input  logic [1:0]          i_ld_a,
    input  logic [REG_W-1:0]    i_rdata,
    output logic [3:0]          o_wmask,
    output logic [REG_W-1:0]    o_wdata,
    output logic [REG_W-1:0]    o_ldata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wmask = i_st_op == SB ? 4'b0001 << i_st_a :
                  i_st_op == SH ? 4'b0011 << {i_st_a[1], 1'b0} :
                  i_st_op == SW ? 4'hF : 4'h0;
        o_wdata = i_st_op == SB ? {4{i_st_data[7:0]}} :
                  i_st_op == SH ? {2{i_st_data[15:0]}} : i_st_data;
        w_byte  = i_rdata[{i_ld_a, 3'b000} +: 8];
        w_half  = i_ld_a[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ldata = i_ld_op == LB  ? {{24{w_byte[7]}}, w_byte} :
                  i_ld_op == LBU ? {24'h0, w_byte} :
                  i_ld_op == LH  ? {{16{w_half[15]}}, w_half} :
                  i_ld_op == LHU ? {16'h0, w_half} : i_rdata;
    end
endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage with req/ack data-memory handshake and writeback register.
// Defining MEM_MISALIGN_CHECK_EN rejects misaligned accesses and adds the misalign output.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [MEM_OP_W-1:0] mem_op_i,
    input  logic [REG_W-1:0]    mem_addr_i,
    input  logic [REG_W-1:0]    store_data_i,
    input  logic [REG_AW-1:0]   reg_waddr_i,
    input  logic                we_i,
    input  logic [REG_W-1:0]    reg_wdata_i,
    stage_mem_if.master         mem,
    output logic                stall_req,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_waddr,
    output logic                wb_we,
    output logic [REG_W-1:0]    wb_wdata,
    output logic                bus_err
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                misalign
`endif
);
    state_e              r_state, w_next;
    logic [7:0]          r_cnt;
    logic [MEM_OP_W-1:0] r_op;
    logic [1:0]          r_a;
    logic                r_we;
    logic [REG_AW-1:0]   r_rd;
    logic                w_ld, w_st, w_mis, w_acc, w_tmo, w_rld;
    logic [3:0]          w_wmask;
    logic [REG_W-1:0]    w_wdata, w_ldata;

    assign w_ld  = is_load(mem_op_i);
    assign w_st  = is_store(mem_op_i);
    assign w_rld = is_load(r_op);
`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = ((mem_op_i == LH || mem_op_i == LHU || mem_op_i == SH) && mem_addr_i[0]) ||
                   ((mem_op_i == LW || mem_op_i == SW) && mem_addr_i[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif
    assign w_acc = valid_i && (w_ld || w_st) && !w_mis;
    assign w_tmo = r_cnt == 8'(ACK_TIMEOUT - 1);

    mem_lane_fmt u_fmt (
        .i_st_op   (mem_op_i),
        .i_st_a    (mem_addr_i[1:0]),
        .i_st_data (store_data_i),
        .i_ld_op   (r_op),
        .i_ld_a    (r_a),
        .i_rdata   (mem.mem_rdata),
        .o_wmask   (w_wmask),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Ack is checked ahead of the timeout, so a last-cycle ack still completes normally
    always_comb begin
        w_next    = r_state;
        stall_req = 1'b0;
        stall_req = r_state == IDLE ? w_acc : !mem.mem_ack;
        w_next    = r_state == IDLE ? (w_acc ? BUSY : IDLE) :
                    (mem.mem_ack || w_tmo) ? IDLE : BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wmask <= '0;
            wb_valid      <= 1'b0;
            wb_waddr      <= '0;
            wb_we         <= 1'b0;
            wb_wdata      <= '0;
            bus_err       <= 1'b0;
            r_cnt         <= '0;
            r_op          <= MEM_NONE;
            r_a           <= '0;
            r_we          <= 1'b0;
            r_rd          <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign      <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign <= r_state == IDLE && valid_i && w_mis;
`endif
            if (r_state == IDLE) begin
                if (valid_i && !(w_ld || w_st)) begin
                    wb_valid <= 1'b1;
                    wb_waddr <= reg_waddr_i;
                    wb_we    <= we_i;
                    wb_wdata <= reg_wdata_i;
                end else if (valid_i && w_mis) begin
                    wb_valid <= 1'b1;
                    wb_waddr <= reg_waddr_i;
                    wb_we    <= 1'b0;
                    wb_wdata <= '0;
                end else if (w_acc) begin
                    mem.mem_req   <= 1'b1;
                    mem.mem_we    <= w_st;
                    mem.mem_addr  <= {mem_addr_i[31:2], 2'b00};
                    mem.mem_wdata <= w_wdata;
                    mem.mem_wmask <= w_wmask;
                    r_op          <= mem_op_i;
                    r_a           <= mem_addr_i[1:0];
                    r_we          <= we_i;
                    r_rd          <= reg_waddr_i;
                    r_cnt         <= '0;
                end
            end else if (mem.mem_ack) begin
                mem.mem_req <= 1'b0;
                wb_valid    <= 1'b1;
                wb_waddr    <= r_rd;
                wb_we       <= w_rld && r_we;
                wb_wdata    <= w_rld ? w_ldata : '0;
                r_cnt       <= '0;
            end else if (w_tmo) begin
                mem.mem_req <= 1'b0;
                bus_err     <= 1'b1;
                wb_valid    <= 1'b1;
                wb_waddr    <= r_rd;
                wb_we       <= 1'b0;
                wb_wdata    <= '0;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed self-checking bench for stage_mem built with ACK_TIMEOUT = 4
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        stall_req, wb_valid, wb_we, bus_err;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif
    int n_chk = 0;
    int n_err = 0;

    logic [3:0]  st_op [3] = '{SB, SH, SW};
    logic [31:0] st_adr[3] = '{32'h3001, 32'h5002, 32'h5004};
    logic [31:0] st_dat[3] = '{32'h0000_00A5, 32'h1234_BEEF, 32'hCAFE_F00D};
    logic [3:0]  st_msk[3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] st_wd [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hCAFE_F00D};

    logic [3:0]  ld_op [5] = '{LB, LH, LW, LBU, LH};
    logic [31:0] ld_adr[5] = '{32'h6001, 32'h6002, 32'h7000, 32'h7002, 32'h6000};
    logic [31:0] ld_rd [5] = '{32'h1122_3344, 32'h8001_0000, 32'hDEAD_BEEF, 32'h00F0_0000, 32'h0000_7FFF};
    logic [31:0] ld_exp[5] = '{32'h0000_0033, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_00F0, 32'h0000_7FFF};

    stage_mem_if mb();

    stage_mem #(.ACK_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .reg_waddr_i  (reg_waddr_i),
        .we_i         (we_i),
        .reg_wdata_i  (reg_wdata_i),
        .mem          (mb),
        .stall_req    (stall_req),
        .wb_valid     (wb_valid),
        .wb_waddr     (wb_waddr),
        .wb_we        (wb_we),
        .wb_wdata     (wb_wdata),
        .bus_err      (bus_err)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign     (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic we, input logic [31:0] d);
        valid_i      = 1'b1;
        mem_op_i     = op;
        mem_addr_i   = addr;
        reg_waddr_i  = rd;
        we_i         = we;
        reg_wdata_i  = d;
        store_data_i = d;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_wdata, mb.mem_wmask,
             wb_valid, wb_we, wb_waddr, wb_wdata, bus_err, stall_req} !== '0) begin
            n_err++;
            $display("FAIL reset: req=%b we=%b addr=%h wdata=%h mask=%b wbv=%b wbwe=%b wba=%0d wbd=%h err=%b stall=%b, want all 0",
                     mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_wdata, mb.mem_wmask,
                     wb_valid, wb_we, wb_waddr, wb_wdata, bus_err, stall_req);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough;
        @(negedge clk);
        drive(MEM_NONE, 32'h0, 5'd5, 1'b1, 32'h1234);
        #1 n_chk++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL pass_stall: got %b want 0", stall_req);
        end
        @(negedge clk);
        n_chk++;
        if ({wb_valid, wb_waddr, wb_we, wb_wdata} !== {1'b1, 5'd5, 1'b1, 32'h1234}) begin
            n_err++;
            $display("FAIL pass_wb: got v=%b a=%0d we=%b d=%h want v=1 a=5 we=1 d=00001234",
                     wb_valid, wb_waddr, wb_we, wb_wdata);
        end
        drive(MEM_NONE, 32'h0, 5'd6, 1'b0, 32'h55);
        @(negedge clk);
        n_chk++;
        if ({wb_valid, wb_waddr, wb_we, wb_wdata} !== {1'b1, 5'd6, 1'b0, 32'h55}) begin
            n_err++;
            $display("FAIL back_to_back_wb: got v=%b a=%0d we=%b d=%h want v=1 a=6 we=0 d=00000055",
                     wb_valid, wb_waddr, wb_we, wb_wdata);
        end
        valid_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pass_pulse: wb_valid got %b want 0", wb_valid);
        end
    endtask

    task automatic test_lb_sign;
        int sc;
        @(negedge clk);
        drive(LB, 32'h1003, 5'd7, 1'b1, 32'h0);
        #1 sc = int'(stall_req);
        repeat (3) begin
            @(negedge clk);
            #1 sc += int'(stall_req);
        end
        @(negedge clk);
        n_chk++;
        if ({mb.mem_req, mb.mem_we, mb.mem_addr} !== {1'b1, 1'b0, 32'h1000}) begin
            n_err++;
            $display("FAIL lb_req: got req=%b we=%b addr=%h want req=1 we=0 addr=00001000",
                     mb.mem_req, mb.mem_we, mb.mem_addr);
        end
        mb.mem_ack   = 1'b1;
        mb.mem_rdata = 32'h80AA_BBCC;
        #1 sc += int'(stall_req);
        @(negedge clk);
        mb.mem_ack = 1'b0;
        valid_i    = 1'b0;
        n_chk++;
        if (sc != 4) begin
            n_err++;
            $display("FAIL lb_stall_cycles: got %0d want 4", sc);
        end
        n_chk++;
        if ({wb_valid, wb_waddr, wb_we, wb_wdata, bus_err, mb.mem_req} !==
            {1'b1, 5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lb_wb: got v=%b a=%0d we=%b d=%h err=%b req=%b want v=1 a=7 we=1 d=ffffff80 err=0 req=0",
                     wb_valid, wb_waddr, wb_we, wb_wdata, bus_err, mb.mem_req);
        end
    endtask

    task automatic test_lhu;
        @(negedge clk);
        drive(LHU, 32'h2002, 5'd9, 1'b1, 32'h0);
        @(negedge clk);
        mb.mem_ack   = 1'b1;
        mb.mem_rdata = 32'h9876_5432;
        #1 n_chk++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL lhu_stall_on_ack: got %b want 0", stall_req);
        end
        @(negedge clk);
        mb.mem_ack = 1'b0;
        valid_i    = 1'b0;
        n_chk++;
        if ({wb_valid, wb_waddr, wb_we, wb_wdata} !== {1'b1, 5'd9, 1'b1, 32'h0000_9876}) begin
            n_err++;
            $display("FAIL lhu_wb: got v=%b a=%0d we=%b d=%h want v=1 a=9 we=1 d=00009876",
                     wb_valid, wb_waddr, wb_we, wb_wdata);
        end
    endtask

    task automatic test_stores;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(st_op[i], st_adr[i], 5'd3, 1'b1, st_dat[i]);
            @(negedge clk);
            n_chk++;
            if ({mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_wmask, mb.mem_wdata} !==
                {1'b1, 1'b1, st_adr[i] & 32'hFFFF_FFFC, st_msk[i], st_wd[i]}) begin
                n_err++;
                $display("FAIL store%0d_bus: got req=%b we=%b addr=%h mask=%b wdata=%h want req=1 we=1 addr=%h mask=%b wdata=%h",
                         i, mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_wmask, mb.mem_wdata,
                         st_adr[i] & 32'hFFFF_FFFC, st_msk[i], st_wd[i]);
            end
            mb.mem_ack = 1'b1;
            @(negedge clk);
            mb.mem_ack = 1'b0;
            valid_i    = 1'b0;
            n_chk++;
            if ({wb_valid, wb_we, mb.mem_req} !== 3'b100) begin
                n_err++;
                $display("FAIL store%0d_wb: got v=%b we=%b req=%b want v=1 we=0 req=0",
                         i, wb_valid, wb_we, mb.mem_req);
            end
        end
    endtask

    task automatic test_loads;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(ld_op[i], ld_adr[i], 5'(10 + i), 1'b1, 32'h0);
            @(negedge clk);
            mb.mem_ack   = 1'b1;
            mb.mem_rdata = ld_rd[i];
            @(negedge clk);
            mb.mem_ack = 1'b0;
            valid_i    = 1'b0;
            n_chk++;
            if ({wb_valid, wb_waddr, wb_we, wb_wdata} !== {1'b1, 5'(10 + i), 1'b1, ld_exp[i]}) begin
                n_err++;
                $display("FAIL load%0d: got v=%b a=%0d we=%b d=%h want v=1 a=%0d we=1 d=%h",
                         i, wb_valid, wb_waddr, wb_we, wb_wdata, 10 + i, ld_exp[i]);
            end
        end
    endtask

    task automatic test_illegal_op;
        @(negedge clk);
        drive(4'd12, 32'h0000_1001, 5'd4, 1'b1, 32'hCAFE);
        #1 n_chk++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_stall: got %b want 0", stall_req);
        end
        @(negedge clk);
        valid_i = 1'b0;
        n_chk++;
        if ({wb_valid, wb_waddr, wb_we, wb_wdata, mb.mem_req} !== {1'b1, 5'd4, 1'b1, 32'hCAFE, 1'b0}) begin
            n_err++;
            $display("FAIL illegal_wb: got v=%b a=%0d we=%b d=%h req=%b want v=1 a=4 we=1 d=0000cafe req=0",
                     wb_valid, wb_waddr, wb_we, wb_wdata, mb.mem_req);
        end
    endtask

    task automatic test_idle_ack;
        @(negedge clk);
        mb.mem_ack   = 1'b1;
        mb.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_chk++;
        if ({wb_valid, mb.mem_req, stall_req, bus_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_ack: got v=%b req=%b stall=%b err=%b want all 0",
                     wb_valid, mb.mem_req, stall_req, bus_err);
        end
        mb.mem_ack = 1'b0;
    endtask

    task automatic test_timeout;
        int rc;
        rc = 0;
        @(negedge clk);
        drive(LW, 32'h8000, 5'd2, 1'b1, 32'h0);
        repeat (4) begin
            @(negedge clk);
            valid_i = 1'b0;
            rc += int'(mb.mem_req);
        end
        @(negedge clk);
        n_chk++;
        if (rc != 4) begin
            n_err++;
            $display("FAIL timeout_req_cycles: got %0d want 4", rc);
        end
        n_chk++;
        if ({mb.mem_req, bus_err, wb_valid, wb_we, wb_waddr} !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd2}) begin
            n_err++;
            $display("FAIL timeout_abort: got req=%b err=%b v=%b we=%b a=%0d want req=0 err=1 v=1 we=0 a=2",
                     mb.mem_req, bus_err, wb_valid, wb_we, wb_waddr);
        end
        @(negedge clk);
        n_chk++;
        if ({bus_err, wb_valid, stall_req} !== 3'b000) begin
            n_err++;
            $display("FAIL timeout_idle: got err=%b v=%b stall=%b want all 0", bus_err, wb_valid, stall_req);
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        drive(LW, 32'h9000, 5'd8, 1'b1, 32'h0);
        @(negedge clk);
        valid_i = 1'b0;
        n_chk++;
        if (mb.mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rstbusy_req_before: got %b want 1", mb.mem_req);
        end
        #2 rst_n = 1'b0;
        #1 n_chk++;
        if ({mb.mem_req, stall_req} !== 2'b00) begin
            n_err++;
            $display("FAIL rstbusy_async: got req=%b stall=%b want 0 0", mb.mem_req, stall_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if ({wb_valid, mb.mem_req, bus_err} !== 3'b000) begin
                n_err++;
                $display("FAIL rstbusy_no_wb: got v=%b req=%b err=%b want all 0", wb_valid, mb.mem_req, bus_err);
            end
        end
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign;
        @(negedge clk);
        drive(LW, 32'h4002, 5'd6, 1'b1, 32'h0);
        #1 n_chk++;
        if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_stall: got %b want 0", stall_req);
        end
        @(negedge clk);
        valid_i = 1'b0;
        n_chk++;
        if ({mb.mem_req, wb_valid, wb_we, misalign} !== 4'b0101) begin
            n_err++;
            $display("FAIL misalign_pulse: got req=%b v=%b we=%b mis=%b want 0 1 0 1",
                     mb.mem_req, wb_valid, wb_we, misalign);
        end
        @(negedge clk);
        n_chk++;
        if ({misalign, mb.mem_req} !== 2'b00) begin
            n_err++;
            $display("FAIL misalign_end: got mis=%b req=%b want 0 0", misalign, mb.mem_req);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mb.mem_ack   = 1'b0;
        mb.mem_rdata = '0;
        test_reset;
        test_passthrough;
        test_lb_sign;
        test_lhu;
        test_stores;
        test_loads;
        test_illegal_op;
        test_idle_ack;
        test_timeout;
        test_reset_busy;
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
